vcr_regbank: RTL and testbench

Parametrised Vendor Command/Request register bank on the EZ-USB 11-line VCR port (8-bit bidirectional data plus dir, set_addr and set_data strobes), clocked by IFCLK. It generalises the fixed-address VCR decoder in three ways:
- configurable banks of multi-byte write registers and read registers;
- atomic commit of multi-byte writes and atomic snapshot of multi-byte reads;
- a range of address-only command pulses.

It sits between the EZ-USB VCR pins and application control/status logic.

---
 rtl/vcr_regbank.sv | 145 ++++++++++++++
 tb/tb_vcr_regbank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vcr_regbank.sv
// Parametrised VCR register bank: multi-byte write registers with atomic commit,
// snapshotted read registers and address-only command pulses. Readback of write
// registers is built only when VCR_REGBANK_READBACK_EN is defined.
module vcr_regbank #(
  parameter int unsigned NUM_WR_REGS = 4,
  parameter int unsigned NUM_RD_REGS = 4,
  parameter int unsigned REG_BYTES   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  BASE_ADDR   = 8'h90
) (
  input  logic                                 IFCLK,
  input  logic                                 RESET_N,
  input  logic                                 CS,
  inout  wire  [7:0]                           vcr_inout,
  input  logic                                 vcr_dir,
  input  logic                                 vcr_set_addr,
  input  logic                                 vcr_set_data,
  output logic [NUM_WR_REGS*REG_BYTES*8-1:0]   wr_regs,
  output logic [NUM_WR_REGS-1:0]               wr_strobe,
  input  logic [NUM_RD_REGS*REG_BYTES*8-1:0]   rd_regs,
  output logic [NUM_RD_REGS-1:0]               rd_snapshot,
  output logic [15:0]                          cmd_pulse
);

  localparam int unsigned BW  = (REG_BYTES   > 1) ? $clog2(REG_BYTES)   : 1;
  localparam int unsigned WIW = (NUM_WR_REGS > 1) ? $clog2(NUM_WR_REGS) : 1;
  localparam int unsigned RIW = (NUM_RD_REGS > 1) ? $clog2(NUM_RD_REGS) : 1;
  localparam logic [7:0]  RD_BASE = BASE_ADDR + 8'h10;

  logic [7:0]                              vcr_in_r;
  logic [7:0]                              vcr_addr;
  logic [7:0]                              vcr_out;
  logic [SYNC_STAGES-1:0]                  addr_sync;
  logic [SYNC_STAGES-1:0]                  data_sync;
  logic                                    addr_prev;
  logic                                    data_prev;
  logic                                    addr_ev;
  logic                                    data_ev;
  logic [BW-1:0]                           byte_idx;
  logic                                    byte_last;
  logic [NUM_WR_REGS-1:0][REG_BYTES-1:0][7:0] wr_q;
  logic [NUM_RD_REGS-1:0][REG_BYTES-1:0][7:0] rd_arr;
  logic [REG_BYTES-1:0][7:0]               shadow;
  logic [REG_BYTES-1:0][7:0]               hold;
  logic [REG_BYTES-1:0][7:0]               commit_val;
  logic [7:0]                              wr_off;
  logic [7:0]                              rd_off;
  logic [7:0]                              new_rd_off;
  logic                                    wr_hit;
  logic                                    rd_hit;
  logic                                    new_rd_hit;
  logic [WIW-1:0]                          wr_idx;
  logic [RIW-1:0]                          rd_idx;
  logic [RIW-1:0]                          new_rd_idx;

  assign rd_arr  = rd_regs;
  assign wr_regs = wr_q;

  assign addr_ev = addr_sync[SYNC_STAGES-1] & ~addr_prev & CS;
  assign data_ev = data_sync[SYNC_STAGES-1] & ~data_prev & CS;

  // Offsets are modulo-256, so each range check is a single unsigned compare
  assign wr_off     = vcr_addr - BASE_ADDR;
  assign rd_off     = vcr_addr - RD_BASE;
  assign new_rd_off = vcr_in_r - RD_BASE;
  assign wr_hit     = 32'(wr_off) < NUM_WR_REGS;
  assign rd_hit     = 32'(rd_off) < NUM_RD_REGS;
  assign new_rd_hit = 32'(new_rd_off) < NUM_RD_REGS;
  assign wr_idx     = wr_off[WIW-1:0];
  assign rd_idx     = rd_off[RIW-1:0];
  assign new_rd_idx = new_rd_off[RIW-1:0];
  assign byte_last  = byte_idx == BW'(REG_BYTES - 1);

  always_comb begin
    commit_val                = shadow;
    commit_val[REG_BYTES-1]   = vcr_in_r;
  end

  always_comb begin
    vcr_out = '0;
    if (rd_hit) begin
      vcr_out = hold[byte_idx];
    end
`ifdef VCR_REGBANK_READBACK_EN
    else if (wr_hit) begin
      vcr_out = wr_q[wr_idx][byte_idx];
    end
`endif
  end

  assign vcr_inout = (RESET_N && CS && vcr_dir) ? vcr_out : 8'bz;

  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vcr_in_r    <= '0;
      vcr_addr    <= '0;
      addr_sync   <= '0;
      data_sync   <= '0;
      addr_prev   <= 1'b0;
      data_prev   <= 1'b0;
      byte_idx    <= '0;
      wr_q        <= '0;
      shadow      <= '0;
      hold        <= '0;
      wr_strobe   <= '0;
      rd_snapshot <= '0;
      cmd_pulse   <= '0;
    end else begin
      vcr_in_r    <= vcr_inout;
      addr_sync   <= {addr_sync[SYNC_STAGES-2:0], vcr_set_addr};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], vcr_set_data};
      addr_prev   <= addr_sync[SYNC_STAGES-1];
      data_prev   <= data_sync[SYNC_STAGES-1];
      wr_strobe   <= '0;
      rd_snapshot <= '0;
      cmd_pulse   <= '0;
      // Address event takes priority; a coincident data event is dropped
      if (addr_ev) begin
        vcr_addr <= vcr_in_r;
        byte_idx <= '0;
        shadow   <= '0;
        if (vcr_in_r[7:4] == 4'hF) begin
          cmd_pulse[vcr_in_r[3:0]] <= 1'b1;
        end
        if (new_rd_hit) begin
          hold                    <= rd_arr[new_rd_idx];
          rd_snapshot[new_rd_idx] <= 1'b1;
        end
      end else if (data_ev) begin
        byte_idx <= byte_last ? '0 : byte_idx + 1'b1;
        if (wr_hit) begin
          shadow[byte_idx] <= vcr_in_r;
          if (byte_last) begin
            wr_q[wr_idx]      <= commit_val;
            wr_strobe[wr_idx] <= 1'b1;
          end
        end else if (rd_hit && byte_last) begin
          hold                <= rd_arr[rd_idx];
          rd_snapshot[rd_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vcr_regbank.sv
// Directed self-checking bench for vcr_regbank (default parameters); expected
// readback values follow VCR_REGBANK_READBACK_EN.
module tb_vcr_regbank;

  logic        IFCLK;
  logic        RESET_N;
  logic        CS;
  logic        vcr_dir;
  logic        vcr_set_addr;
  logic        vcr_set_data;
  logic [63:0] wr_regs;
  logic [3:0]  wr_strobe;
  logic [63:0] rd_regs;
  logic [3:0]  rd_snapshot;
  logic [15:0] cmd_pulse;
  logic        drv_en;
  logic [7:0]  drv_val;
  tri1  [7:0]  vcr_bus;

  // Pulled-up bus: an undriven (Z) bus reads back as 8'hFF
  assign vcr_bus = drv_en ? drv_val : 8'bz;

  vcr_regbank dut (
    .IFCLK        (IFCLK),
    .RESET_N      (RESET_N),
    .CS           (CS),
    .vcr_inout    (vcr_bus),
    .vcr_dir      (vcr_dir),
    .vcr_set_addr (vcr_set_addr),
    .vcr_set_data (vcr_set_data),
    .wr_regs      (wr_regs),
    .wr_strobe    (wr_strobe),
    .rd_regs      (rd_regs),
    .rd_snapshot  (rd_snapshot),
    .cmd_pulse    (cmd_pulse)
  );

  initial IFCLK = 1'b0;
  always #5 IFCLK = ~IFCLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wr = 0;
  int          n_snap = 0;
  int          n_cmd = 0;
  logic [3:0]  wr_last = '0;
  logic [3:0]  snap_last = '0;
  logic [15:0] cmd_last = '0;
  int          base_wr;
  int          base_snap;
  int          base_cmd;

  always @(negedge IFCLK) begin
    if (wr_strobe != 4'h0) begin
      n_wr++;
      wr_last = wr_strobe;
    end
    if (rd_snapshot != 4'h0) begin
      n_snap++;
      snap_last = rd_snapshot;
    end
    if (cmd_pulse != 16'h0) begin
      n_cmd++;
      cmd_last = cmd_pulse;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_strobe(input logic a, input logic d);
    repeat (2) @(negedge IFCLK);
    vcr_set_addr = a;
    vcr_set_data = d;
    repeat (5) @(negedge IFCLK);
    vcr_set_addr = 1'b0;
    vcr_set_data = 1'b0;
    repeat (5) @(negedge IFCLK);
  endtask

  task automatic host_addr(input logic [7:0] a);
    vcr_dir = 1'b0;
    drv_en  = 1'b1;
    drv_val = a;
    pulse_strobe(1'b1, 1'b0);
  endtask

  task automatic host_data(input logic [7:0] d);
    vcr_dir = 1'b0;
    drv_en  = 1'b1;
    drv_val = d;
    pulse_strobe(1'b0, 1'b1);
  endtask

  task automatic host_rd_next();
    vcr_dir = 1'b1;
    drv_en  = 1'b0;
    pulse_strobe(1'b0, 1'b1);
  endtask

  task automatic expect_bus(input string tag, input logic [7:0] e);
    vcr_dir = 1'b1;
    drv_en  = 1'b0;
    @(negedge IFCLK);
    chk(tag, 64'(vcr_bus), 64'(e));
  endtask

  logic [7:0] rb0;
  logic [7:0] rb1;

  initial begin
`ifdef VCR_REGBANK_READBACK_EN
    rb0 = 8'h34;
    rb1 = 8'h12;
`else
    rb0 = 8'h00;
    rb1 = 8'h00;
`endif
    RESET_N      = 1'b0;
    CS           = 1'b1;
    vcr_dir      = 1'b1;
    vcr_set_addr = 1'b0;
    vcr_set_data = 1'b0;
    drv_en       = 1'b0;
    drv_val      = 8'h00;
    rd_regs      = '0;
    repeat (3) @(negedge IFCLK);
    chk("rst_wr_regs", wr_regs, 64'h0);
    chk("rst_pulses", {40'h0, wr_strobe, rd_snapshot, cmd_pulse}, 64'h0);
    chk("rst_bus_z", 64'(vcr_bus), 64'hFF);
    RESET_N = 1'b1;
    repeat (2) @(negedge IFCLK);

    host_addr(8'h90);
    expect_bus("rd_90_initial", 8'h00);

    // Write commit to register 1
    base_wr = n_wr;
    host_addr(8'h91);
    host_data(8'h34);
    chk("partial_hidden", wr_regs, 64'h0);
    chk("partial_no_strobe", 64'(n_wr - base_wr), 64'd0);
    host_data(8'h12);
    chk("commit_value", wr_regs, 64'h0000_0000_1234_0000);
    chk("commit_strobe_cnt", 64'(n_wr - base_wr), 64'd1);
    chk("commit_strobe_bit", 64'(wr_last), 64'h2);

    expect_bus("readback_b0", rb0);
    host_rd_next();
    expect_bus("readback_b1", rb1);

    // Aborted partial write
    base_wr = n_wr;
    host_addr(8'h91);
    host_data(8'hAA);
    host_addr(8'h92);
    chk("abort_value", wr_regs, 64'h0000_0000_1234_0000);
    chk("abort_no_strobe", 64'(n_wr - base_wr), 64'd0);

    // Atomic read of register 2
    rd_regs   = 64'h0000_BEEF_0000_0000;
    base_snap = n_snap;
    host_addr(8'hA2);
    chk("snap_cnt_addr", 64'(n_snap - base_snap), 64'd1);
    chk("snap_bit", 64'(snap_last), 64'h4);
    rd_regs = '0;
    expect_bus("atomic_b0", 8'hEF);
    host_rd_next();
    expect_bus("atomic_b1", 8'hBE);
    host_rd_next();
    expect_bus("resnap_b0", 8'h00);
    chk("snap_cnt_wrap", 64'(n_snap - base_snap), 64'd2);

    // Command pulses
    base_cmd = n_cmd;
    host_addr(8'hF5);
    chk("cmd_cycles", 64'(n_cmd - base_cmd), 64'd1);
    chk("cmd_value", 64'(cmd_last), 64'h0020);
    base_cmd = n_cmd;
    host_addr(8'h55);
    chk("noncmd_no_pulse", 64'(n_cmd - base_cmd), 64'd0);
    expect_bus("rd_55_b0", 8'h00);
    host_rd_next();
    expect_bus("rd_55_b1", 8'h00);

    // Chip select gating
    base_wr = n_wr;
    CS = 1'b0;
    host_addr(8'h91);
    host_data(8'h77);
    host_data(8'h77);
    chk("cs_wr_regs", wr_regs, 64'h0000_0000_1234_0000);
    chk("cs_no_strobe", 64'(n_wr - base_wr), 64'd0);
    expect_bus("cs_bus_z", 8'hFF);
    CS = 1'b1;
    expect_bus("cs_addr_kept", 8'h00);

    // Simultaneous address and data edges
    base_wr = n_wr;
    host_addr(8'h91);
    host_data(8'h11);
    vcr_dir = 1'b0;
    drv_en  = 1'b1;
    drv_val = 8'h93;
    pulse_strobe(1'b1, 1'b1);
    chk("simul_no_commit", wr_regs, 64'h0000_0000_1234_0000);
    chk("simul_no_strobe", 64'(n_wr - base_wr), 64'd0);
    host_data(8'h22);
    chk("simul_idx0", 64'(n_wr - base_wr), 64'd0);
    host_data(8'h33);
    chk("simul_commit3", wr_regs, 64'h3322_0000_1234_0000);
    chk("simul_strobe3", 64'(wr_last), 64'h8);

    // Reset in the middle of a write
    host_addr(8'h90);
    host_data(8'h5A);
    vcr_dir = 1'b1;
    drv_en  = 1'b0;
    RESET_N = 1'b0;
    repeat (2) @(negedge IFCLK);
    chk("midrst_wr_regs", wr_regs, 64'h0);
    chk("midrst_pulses", {40'h0, wr_strobe, rd_snapshot, cmd_pulse}, 64'h0);
    chk("midrst_bus_z", 64'(vcr_bus), 64'hFF);
    RESET_N = 1'b1;
    repeat (2) @(negedge IFCLK);
    host_addr(8'h90);
    expect_bus("post_rst_rd90", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
